// File: rtl/object_sprite_mem.sv
`default_nettype none
// ============================================================================
// Module   : object_sprite_mem
// Purpose  : Sprite store plus raster reader. On start, streams every pixel
//            of the selected animation frame in raster order over a
//            valid/ready handshake, with x/y offsets and a last flag.
// Options  : OBJECT_MEM_WRITE_EN adds a write port (simple dual-port memory).
// Revision : 1.0 - initial release
// ============================================================================
module object_sprite_mem #(
   parameter int n         = 3,
   parameter int XB        = 3,
   parameter int YB        = 3,
   parameter int FB        = 1,
   parameter     INIT_FILE = "object_160_12.mif"
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                start,
   input  logic [FB-1:0]       frame,
   input  logic                ready,
   output logic                busy,
   output logic                valid,
   output logic [XB-1:0]       x_off,
   output logic [YB-1:0]       y_off,
   output logic [n-1:0]        color,
   output logic                last,
   output logic                done
`ifdef OBJECT_MEM_WRITE_EN
   ,
   input  logic                wr_en,
   input  logic [FB+YB+XB-1:0] wr_addr,
   input  logic [n-1:0]        wr_data
`endif
);

   localparam int c_PB    = XB + YB;
   localparam int c_AW    = FB + c_PB;
   localparam int c_DEPTH = 1 << c_AW;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRIME  = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   logic [FB-1:0]     r_frame;
   logic [c_PB-1:0]   r_cnt;
   logic [c_PB-1:0]   w_cnt_next;
   logic [c_AW-1:0]   w_rd_addr;
   logic              r_busy;
   logic              r_valid;
   logic              r_last;
   logic              r_done;
   logic [n-1:0]      r_color;

   logic              w_wr_en;
   logic [c_AW-1:0]   w_wr_addr;
   logic [n-1:0]      w_wr_data;

   (* ram_init_file = INIT_FILE *)
   logic [n-1:0]      r_mem [c_DEPTH];

`ifdef OBJECT_MEM_WRITE_EN
   assign w_wr_en   = wr_en;
   assign w_wr_addr = wr_addr;
   assign w_wr_data = wr_data;
`else
   // Without the write option the array is a pure ROM; the write path folds away.
   assign w_wr_en   = 1'b0;
   assign w_wr_addr = '0;
   assign w_wr_data = '0;
`endif

   // Pixel counter for the next cycle; it also addresses the memory so that the
   // registered colour always lines up with the registered offsets.
   always_comb begin
      w_cnt_next = r_cnt;
      case (r_state)
         S_IDLE:   if (start) w_cnt_next = '0;
         S_STREAM: if (ready) w_cnt_next = r_cnt + c_PB'(1);
         default:  w_cnt_next = r_cnt;
      endcase
   end

   assign w_rd_addr = {r_frame, w_cnt_next};

   // Write port; a same-cycle read of the written word still sees old data.
   always_ff @(posedge clock) begin
      if (w_wr_en)
         r_mem[w_wr_addr] <= w_wr_data;
   end

   // Synchronous read: colour is valid the cycle after the address is presented.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         r_color <= '0;
      else
         r_color <= r_mem[w_rd_addr];
   end

   // Control FSM with registered handshake and status outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_frame <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_frame <= frame;
                  r_busy  <= 1'b1;
                  r_state <= S_PRIME;
               end
            end
            S_PRIME: begin
               r_valid <= 1'b1;
               r_last  <= &w_cnt_next;
               r_state <= S_STREAM;
            end
            S_STREAM: begin
               if (ready) begin
                  if (r_last) begin
                     // Final pixel accepted; the counter has wrapped to zero.
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_last  <= &w_cnt_next;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy  = r_busy;
   assign valid = r_valid;
   assign last  = r_last;
   assign done  = r_done;
   assign color = r_color;
   assign x_off = r_cnt[XB-1:0];
   assign y_off = r_cnt[c_PB-1:XB];

endmodule
`default_nettype wire

// File: tb/tb_object_sprite_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_object_sprite_mem
// Purpose  : Self-checking bench for object_sprite_mem against a pixel-index
//            reference model (raster position -> offsets, colour, last).
// Revision : 1.0 - initial release
// ============================================================================
module tb_object_sprite_mem;

   localparam int N_W    = 3;
   localparam int XB     = 3;
   localparam int YB     = 3;
   localparam int FB     = 1;
   localparam int AW     = FB + YB + XB;
   localparam int W      = 1 << XB;
   localparam int NPIX   = 1 << (XB + YB);
   localparam int NWORDS = 1 << AW;
   localparam int VW     = 4 + YB + XB + N_W;

   logic            clock  = 1'b0;
   logic            resetn = 1'b0;
   logic            start  = 1'b0;
   logic            ready  = 1'b0;
   logic [FB-1:0]   frame  = '0;
   logic            busy, valid, last, done;
   logic [XB-1:0]   x_off;
   logic [YB-1:0]   y_off;
   logic [N_W-1:0]  color;
`ifdef OBJECT_MEM_WRITE_EN
   logic            wr_en   = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [N_W-1:0]  wr_data = '0;
`endif

   logic [N_W-1:0]  model_mem [NWORDS];
   int              n_checks = 0;
   int              n_fail   = 0;

   always #5 clock = ~clock;

   object_sprite_mem #(
      .n         (N_W),
      .XB        (XB),
      .YB        (YB),
      .FB        (FB),
      .INIT_FILE ("object_160_12.mif")
   ) dut (
      .clock   (clock),
      .resetn  (resetn),
      .start   (start),
      .frame   (frame),
      .ready   (ready),
      .busy    (busy),
      .valid   (valid),
      .x_off   (x_off),
      .y_off   (y_off),
      .color   (color),
      .last    (last),
      .done    (done)
`ifdef OBJECT_MEM_WRITE_EN
      ,
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
`endif
   );

   // The sprite file is not readable here, so a random image is placed in the
   // array and mirrored in the model.
   task automatic load_image();
      logic [N_W-1:0] v;
      logic [AW-1:0]  a;
      for (int i = 0; i < NWORDS; i++) begin
         v = N_W'($urandom);
         a = AW'(i);
         model_mem[i]  = v;
         dut.r_mem[a]  = v;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start  = 1'b1;
      ready  = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_checks++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy);  end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_checks++; if (done  !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done);  end
      n_checks++; if (last  !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", last);  end
      n_checks++; if (color !== '0)   begin n_fail++; $display("FAIL reset_color: got %0d want 0", color); end
      n_checks++; if (x_off !== '0)   begin n_fail++; $display("FAIL reset_x: got %0d want 0", x_off);   end
      n_checks++; if (y_off !== '0)   begin n_fail++; $display("FAIL reset_y: got %0d want 0", y_off);   end
      start  = 1'b0;
      ready  = 1'b0;
      resetn = 1'b1;
      @(posedge clock); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating;
   // mode 2: random ready with random start/frame noise while busy.
   // stop_at >= 0 leaves the run once that many pixels are accepted.
   task automatic run_stream(input logic [FB-1:0] f, input int mode, input bit chg,
                             input int stop_at, input bit do_wr);
      int             p;
      int             cyc;
      int             base;
      logic           r;
      logic [VW-1:0]  exp_v;
      logic [VW-1:0]  got_v;
      base  = int'(f) * NPIX;
      start = 1'b1;
      frame = f;
      ready = 1'b0;
      @(posedge clock); #1;
      start = 1'b0;
      if (chg) frame = ~f;
      n_checks++;
      if ({busy, valid, done} !== 3'b100) begin
         n_fail++; $display("FAIL prime_state: busy/valid/done got %b want 100", {busy, valid, done});
      end
      @(posedge clock); #1;
      p   = 0;
      cyc = 0;
      while (p < NPIX && p != stop_at && cyc < 8 * NPIX) begin
         exp_v = {1'b1, 1'b1, 1'b0, (p == NPIX - 1), YB'(p / W), XB'(p % W), model_mem[base + p]};
         got_v = {busy, valid, done, last, y_off, x_off, color};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL pixel %0d frame %0d: {busy,valid,done,last,y,x,color} got %h want %h",
                     p, f, got_v, exp_v);
         end
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: begin
               r     = ($urandom % 3) != 0;
               start = 1'($urandom);
               frame = FB'($urandom);
            end
         endcase
         ready = r;
`ifdef OBJECT_MEM_WRITE_EN
         wr_en = 1'b0;
         if (do_wr && cyc == 10) begin
            wr_en         = 1'b1;
            wr_addr       = AW'(70);
            wr_data       = ~model_mem[70];
            model_mem[70] = ~model_mem[70];
         end
`endif
         @(posedge clock); #1;
         if (r) p++;
         cyc++;
      end
      start = 1'b0;
      ready = 1'b0;
`ifdef OBJECT_MEM_WRITE_EN
      wr_en = 1'b0;
`endif
      if (p == stop_at) return;
      n_checks++;
      if (p != NPIX) begin
         n_fail++; $display("FAIL stream_timeout: accepted %0d want %0d", p, NPIX);
         return;
      end
      n_checks++;
      if ({busy, valid, done, last} !== 4'b1010) begin
         n_fail++; $display("FAIL done_pulse: busy/valid/done/last got %b want 1010", {busy, valid, done, last});
      end
      @(posedge clock); #1;
      n_checks++;
      if ({busy, valid, done, last} !== 4'b0000) begin
         n_fail++; $display("FAIL back_idle: busy/valid/done/last got %b want 0000", {busy, valid, done, last});
      end
   endtask

   task automatic test_frame0();
      run_stream(1'b0, 0, 1'b0, -1, 1'b0);
   endtask

   task automatic test_frame_change();
      run_stream(1'b1, 0, 1'b1, -1, 1'b0);
   endtask

   task automatic test_ready_pattern();
      run_stream(1'b0, 1, 1'b0, -1, 1'b0);
      run_stream(1'b1, 1, 1'b0, -1, 1'b0);
   endtask

   task automatic test_reset_mid();
      run_stream(1'b1, 0, 1'b0, 21, 1'b0);
      resetn = 1'b0;
      #1;
      n_checks++;
      if ({busy, valid, done, last, x_off, y_off, color} !== '0) begin
         n_fail++; $display("FAIL async_reset: outputs got %h want 0",
                            {busy, valid, done, last, x_off, y_off, color});
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         n_checks++;
         if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_hold %0d: busy/done got %b want 00", i, {busy, done});
         end
      end
      resetn = 1'b1;
      @(posedge clock); #1;
      run_stream(1'b1, 0, 1'b0, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++)
         run_stream(FB'($urandom), 2, 1'b0, -1, 1'b0);
   endtask

`ifdef OBJECT_MEM_WRITE_EN
   task automatic test_write();
      wr_en   = 1'b1;
      wr_addr = AW'(5);
      wr_data = 3'b101;
      model_mem[5] = 3'b101;
      @(posedge clock); #1;
      wr_en = 1'b0;
      run_stream(1'b0, 0, 1'b0, -1, 1'b1);
      run_stream(1'b1, 0, 1'b0, -1, 1'b0);
   endtask
`endif

   initial begin
      load_image();
      test_reset();
      test_frame0();
      test_frame_change();
      test_ready_pattern();
      test_reset_mid();
      test_back_to_back();
`ifdef OBJECT_MEM_WRITE_EN
      test_write();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
